// File: rtl/fu_wb_arbiter_pkg.sv
// rtl/fu_wb_arbiter_pkg.sv - shared widths, result record type and round-robin helper
package fu_pkg;

    localparam int NUM_FU_DEF       = 4;
    localparam int NUM_WB_DEF       = 2;
    localparam int DEPTH_DEF        = 4;
    localparam int INST_ID_BITS_DEF = 6;
    localparam int PRN_BITS_DEF     = 6;
    localparam int MAX_OPERANDS_DEF = 3;
    localparam int DATA_BITS        = 64;

    // Slot s of prn/data/data_valid lines up with slot s of the flat port vectors.
    typedef struct packed {
        logic [INST_ID_BITS_DEF-1:0]                     inst_id;
        logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0]   prn;
        logic [MAX_OPERANDS_DEF-1:0][DATA_BITS-1:0]      data;
        logic [MAX_OPERANDS_DEF-1:0]                     data_valid;
    } fu_result_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// rtl/fu_wb_arbiter_if.sv - FU result / writeback bus bundle with master and slave views
interface fu_wb_if
    import fu_pkg::*;
#(
    parameter int NUM_FU       = NUM_FU_DEF,
    parameter int NUM_WB       = NUM_WB_DEF,
    parameter int INST_ID_BITS = INST_ID_BITS_DEF,
    parameter int PRN_BITS     = PRN_BITS_DEF,
    parameter int MAX_OPERANDS = MAX_OPERANDS_DEF
);
    localparam int FU_IDX_BITS = $clog2(NUM_FU);

    logic                                     flush;
    logic [NUM_FU-1:0]                        fu_out_valid;
    logic [NUM_FU*INST_ID_BITS-1:0]           fu_out_inst_id;
    logic [NUM_FU*MAX_OPERANDS*PRN_BITS-1:0]  fu_out_prn;
    logic [NUM_FU*MAX_OPERANDS*DATA_BITS-1:0] fu_out_data;
    logic [NUM_FU*MAX_OPERANDS-1:0]           fu_out_data_valid;
    logic [NUM_FU-1:0]                        fu_res_ready;
    logic [NUM_WB-1:0]                        wb_valid;
    logic [NUM_WB-1:0]                        wb_ready;
    logic [NUM_WB*INST_ID_BITS-1:0]           wb_inst_id;
    logic [NUM_WB*MAX_OPERANDS*PRN_BITS-1:0]  wb_prn;
    logic [NUM_WB*MAX_OPERANDS*DATA_BITS-1:0] wb_data;
    logic [NUM_WB*MAX_OPERANDS-1:0]           wb_data_valid;
    logic [NUM_WB*FU_IDX_BITS-1:0]            wb_src_fu;
    logic                                     res_pending;

    modport master (
        output flush, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_data_valid, wb_ready,
        input  fu_res_ready, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid,
               wb_src_fu, res_pending
    );

    modport slave (
        input  flush, fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data,
               fu_out_data_valid, wb_ready,
        output fu_res_ready, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid,
               wb_src_fu, res_pending
    );

endinterface

// File: rtl/fu_wb_arbiter_fifo.sv
// rtl/fu_wb_arbiter_fifo.sv - per-channel result FIFO with registered count and sync flush
module fu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;

    // Full/empty come from the registered count only, so no pop-to-push bypass exists.
    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - buffers FU results per channel and round-robins them onto writeback ports
module fu_wb_arbiter
    import fu_pkg::*;
#(
    parameter int NUM_FU       = NUM_FU_DEF,
    parameter int NUM_WB       = NUM_WB_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int INST_ID_BITS = INST_ID_BITS_DEF,
    parameter int PRN_BITS     = PRN_BITS_DEF,
    parameter int MAX_OPERANDS = MAX_OPERANDS_DEF
) (
    input  logic    clk,
    input  logic    rst,
    fu_wb_if.slave  bus
);
    localparam int IDX_BITS  = $clog2(NUM_FU);
    localparam int SLOT_BITS = $clog2(NUM_WB + 1);
    localparam int PRN_W     = MAX_OPERANDS * PRN_BITS;
    localparam int DATA_W    = MAX_OPERANDS * DATA_BITS;
    localparam int REC_W     = INST_ID_BITS + PRN_W + DATA_W + MAX_OPERANDS;

    logic [NUM_FU-1:0]    full;
    logic [NUM_FU-1:0]    empty;
    logic [NUM_FU-1:0]    push;
    logic [NUM_FU-1:0]    pop;
    logic [REC_W-1:0]     push_rec [NUM_FU];
    logic [REC_W-1:0]     head_rec [NUM_FU];
    logic [NUM_WB-1:0]    grant_valid;
    logic [IDX_BITS-1:0]  grant_fu [NUM_WB];
    logic [IDX_BITS-1:0]  rr_ptr;
    logic [IDX_BITS:0]    scan_pos;
    logic [IDX_BITS-1:0]  scan_idx;
    logic [SLOT_BITS-1:0] slot;
    logic                 xfer_any;
    logic [IDX_BITS-1:0]  xfer_last;

    // Record layout, LSB first: inst_id, prn slots, data slots, data_valid bits.
    for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
        assign push_rec[i] = {bus.fu_out_data_valid[i*MAX_OPERANDS +: MAX_OPERANDS],
                              bus.fu_out_data[i*DATA_W +: DATA_W],
                              bus.fu_out_prn[i*PRN_W +: PRN_W],
                              bus.fu_out_inst_id[i*INST_ID_BITS +: INST_ID_BITS]};
        assign push[i] = bus.fu_out_valid[i] & ~full[i];

        fu_result_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .push      (push[i]),
            .push_data (push_rec[i]),
            .full      (full[i]),
            .pop       (pop[i]),
            .head      (head_rec[i]),
            .empty     (empty[i])
        );
    end

    assign bus.fu_res_ready = ~full & {NUM_FU{rst}};
    assign bus.res_pending  = ~&empty;

    // Scan from rr_ptr; the k-th non-empty channel found lands on port k.
    always_comb begin
        grant_valid = '0;
        for (int k = 0; k < NUM_WB; k++) grant_fu[k] = '0;
        slot     = '0;
        scan_pos = '0;
        scan_idx = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            scan_pos = {1'b0, rr_ptr} + (IDX_BITS+1)'(j);
            if (scan_pos >= (IDX_BITS+1)'(NUM_FU)) scan_pos = scan_pos - (IDX_BITS+1)'(NUM_FU);
            scan_idx = scan_pos[IDX_BITS-1:0];
            if (!empty[scan_idx]) begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (slot == SLOT_BITS'(k)) begin
                        grant_valid[k] = 1'b1;
                        grant_fu[k]    = scan_idx;
                    end
                end
                if (slot < SLOT_BITS'(NUM_WB)) slot = slot + SLOT_BITS'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_WB; k++) begin : g_port
        logic [REC_W-1:0] rec;
        assign rec = head_rec[grant_fu[k]];
        assign bus.wb_valid[k] = grant_valid[k];
        assign bus.wb_inst_id[k*INST_ID_BITS +: INST_ID_BITS]     = rec[0 +: INST_ID_BITS];
        assign bus.wb_prn[k*PRN_W +: PRN_W]                       = rec[INST_ID_BITS +: PRN_W];
        assign bus.wb_data[k*DATA_W +: DATA_W]                    = rec[INST_ID_BITS+PRN_W +: DATA_W];
        assign bus.wb_data_valid[k*MAX_OPERANDS +: MAX_OPERANDS]  = rec[REC_W-1 -: MAX_OPERANDS];
        assign bus.wb_src_fu[k*IDX_BITS +: IDX_BITS]              = grant_fu[k];
    end

    // Pop granted channels whose port accepted; the highest accepted port is latest in scan order.
    always_comb begin
        pop       = '0;
        xfer_any  = 1'b0;
        xfer_last = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (grant_valid[k] && bus.wb_ready[k]) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (grant_fu[k] == IDX_BITS'(i)) pop[i] = 1'b1;
                end
                xfer_any  = 1'b1;
                xfer_last = grant_fu[k];
            end
        end
    end

    // Round-robin pointer moves just past the last channel served, holds when nothing moved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (bus.flush) begin
            rr_ptr <= '0;
        end else if (xfer_any) begin
            rr_ptr <= IDX_BITS'(rr_next(32'(xfer_last), NUM_FU));
        end
    end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Collects completed results from NUM_FU functional units and drives them onto NUM_WB writeback ports.
- Each FU channel has its own result FIFO of depth DEPTH; a round-robin arbiter grants at most NUM_WB FU heads per cycle.
- Adds the result-side backpressure that a bare FU result port lacks: FUs may stall on fu_res_ready.
- Sits between the FU result ports and the PRF write / ROB-complete logic.

Parameters:
- NUM_FU, 4, number of FU result channels (>=2)
- NUM_WB, 2, number of writeback ports (1..NUM_FU)
- DEPTH, 4, entries per channel FIFO (power of 2, >=2)
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, result slots per instruction

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush of all buffered results
- fu_out_valid  input  NUM_FU  per-FU result valid
- fu_out_inst_id  input  NUM_FU*INST_ID_BITS  per-FU instruction ID
- fu_out_prn  input  NUM_FU*MAX_OPERANDS*PRN_BITS  per-FU destination PRNs
- fu_out_data  input  NUM_FU*MAX_OPERANDS*64  per-FU result data
- fu_out_data_valid  input  NUM_FU*MAX_OPERANDS  per-slot data valid
- fu_res_ready  output  NUM_FU  channel can accept a result this cycle
- wb_valid  output  NUM_WB  writeback port carries a result
- wb_ready  input  NUM_WB  writeback port consumes this cycle
- wb_inst_id  output  NUM_WB*INST_ID_BITS  instruction ID per port
- wb_prn  output  NUM_WB*MAX_OPERANDS*PRN_BITS  PRNs per port
- wb_data  output  NUM_WB*MAX_OPERANDS*64  data per port
- wb_data_valid  output  NUM_WB*MAX_OPERANDS  slot valid per port
- wb_src_fu  output  NUM_WB*$clog2(NUM_FU)  granted FU index per port
- res_pending  output  1  any channel FIFO non-empty

Behaviour:
- Reset (rst low, asynchronous):
  - All FIFO counts and pointers = 0; rr_ptr = 0.
  - wb_valid = 0, fu_res_ready = 0 (forced low while rst is low), res_pending = 0.
  - First cycle after release: fu_res_ready all 1.
- Enqueue: channel i writes when fu_out_valid[i] & fu_res_ready[i].
- fu_res_ready[i] = !full[i], derived from the registered count only. There is no combinational path from wb_ready.
- Full channel:
  - fu_res_ready = 0 even if the head dequeues in the same cycle; there is no full-bypass.
  - fu_out_valid while not ready is ignored. The FU must hold its result.
- Empty channel: no bypass. Minimum latency is 1 cycle from accept to wb_valid.
- A result with all fu_out_data_valid bits = 0 is still enqueued and written back, since it signals completion only.
- Arbitration (combinational from FIFO heads and rr_ptr):
  - Scan channels starting at rr_ptr, wrapping modulo NUM_FU.
  - The k-th non-empty channel found goes to wb port k, for k < NUM_WB.
  - Each channel is granted at most one port per cycle, which preserves per-FU order.
  - Unused ports have wb_valid = 0 and payload don't-care (wb_src_fu = 0).
- Transfer/dequeue:
  - A port transfers when wb_valid[k] & wb_ready[k]; only then does the granted channel pop.
  - wb_valid never depends on wb_ready.
  - Payload of a non-accepted port need not be stable next cycle; re-arbitration is allowed.
- Fairness:
  - If at least one transfer occurs, rr_ptr <= (highest-scan-order accepted channel + 1) mod NUM_FU.
  - Otherwise rr_ptr holds.
- Flush:
  - All counts and pointers = 0 next cycle; rr_ptr = 0.
  - Same-cycle enqueues are dropped.
  - Same-cycle wb transfers are still presented; the consumer must qualify with its own flush.
  - fu_res_ready is unaffected in the flush cycle.
- Simultaneous enqueue and dequeue on a non-full channel: count unchanged, both pointers advance, wrapping at DEPTH.
- res_pending = OR of the non-empty flags, registered-count based.

Decomposition:
- Package fu_pkg:
  - fu_result_t struct: inst_id, prn[MAX_OPERANDS], data[MAX_OPERANDS], data_valid[MAX_OPERANDS].
  - Default widths as localparams.
  - Function rr_next(idx, n).
- Sub-module fu_result_fifo: one per channel, generate loop.
  - Ports: push, push_data, full, pop, head, empty, flush.
  - Contains the count register ($clog2(DEPTH)+1 bits) and the storage array.
- Arbiter and rr_ptr stay in fu_wb_arbiter.

Test Plan:
- Reset then single push: FU1 pushes inst_id=5, prn0=12, data0=0xDEAD, wb_ready=11 -> next cycle wb_valid=01, wb_inst_id[0]=5, wb_src_fu[0]=1; res_pending drops to 0 after the transfer.
- Contention: all 4 FUs push simultaneously with rr_ptr=0 and NUM_WB=2 -> cycle 1 grants FU0 and FU1; cycle 2 grants FU2 and FU3; rr_ptr is 2 then 0.
- Backpressure/full: wb_ready=00 while FU2 pushes 5 results -> fu_res_ready[2]=0 after 4 accepts; 5th held; with wb_ready=11, results drain in order ids 0,1,2,3,4, one per cycle.
- Port stall: wb_ready=10 with FU0 and FU3 non-empty -> only the port-1 grant (FU3) pops; FU0 stays at head.
- Flush: 3 results buffered, flush asserted together with an FU0 push -> all counts 0 next cycle, res_pending=0, the pushed result never appears.
- Async reset mid-operation: rst low between clock edges with full FIFOs -> wb_valid=0 and fu_res_ready=0 immediately; after release fu_res_ready=1111 and no stale results appear.
